// File: rtl/div_ctrl_pkg.sv
// Shared encodings and helpers for the multi-cycle restoring divider.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int unsigned DoubleRegBus = 64;
  localparam logic [5:0]  DivSteps     = 6'd32;

  function automatic logic [31:0] abs_if(input logic en, input logic [31:0] v);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider request/result bundle.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                    signed_div_i;
  logic [31:0]             opdata1_i;
  logic [31:0]             opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_ctrl_step.sv
// One restoring-division step: trial-subtract on the 33-bit window w[64:32], shift in the quotient bit.
module div_step (
  input  logic [64:0] w_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] w_o
);
  logic [32:0] trial;

  always_comb begin
    trial = w_i[64:32] - {1'b0, divisor_i};
    // Borrow out of bit 32 means the window was smaller than the divisor.
    if (trial[32]) begin
      w_o = {w_i[63:0], 1'b0};
    end else begin
      w_o = {trial[31:0], w_i[31:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned 32-bit divider controller; result = {remainder, quotient}.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  div_state_e              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [64:0]             w_q, w_d, w_step;
  logic [31:0]             divisor_q, divisor_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;
  logic [31:0]             quo_fix, rem_fix;

  div_step u_step (
    .w_i       (w_q),
    .divisor_i (divisor_q),
    .w_o       (w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      w_q       <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      DivFree: begin
        if (bus.annul_i) begin
          cnt_d = '0;
          w_d   = '0;
        end else if (bus.start_i == DivStart) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            // Magnitudes are divided; the sign bits are kept for the final fix-up.
            state_d   = DivOn;
            cnt_d     = '0;
            w_d       = {32'b0, abs_if(bus.signed_div_i, bus.opdata1_i), 1'b0};
            divisor_d = abs_if(bus.signed_div_i, bus.opdata2_i);
            neg_quo_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d = bus.signed_div_i & bus.opdata1_i[31];
          end
        end
      end
      DivByZero: begin
        state_d = bus.annul_i ? DivFree : DivEnd;
        cnt_d   = '0;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
          w_d     = '0;
        end else if (cnt_q != DivSteps) begin
          w_d   = w_step;
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d = DivEnd;
          cnt_d   = '0;
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  always_comb begin
    quo_fix  = neg_if(neg_quo_q, w_q[31:0]);
    rem_fix  = neg_if(neg_rem_q, w_q[64:33]);
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = bus.annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (!bus.annul_i && cnt_q == DivSteps) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide-by-zero, annul and reset.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div_ctrl_if bus();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive a request at the falling edge; returns just after edge E samples it.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    @(posedge clk);
  endtask

  // Number of edges after E until ready_o is seen; 0 if the bound expires.
  task automatic wait_ready(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic release_start;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #2;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL reset_state got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
    end
    repeat (2) @(posedge clk);
    // Start presented together with reset release: must be taken on the first edge.
    @(negedge clk);
    rst = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk);
    wait_ready(40, n);
    total++;
    if (n !== 33) begin
      bad++;
      $display("FAIL first_start_latency got=%0d want=33", n);
    end
    total++;
    if (bus.result_o !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL first_start_result got=%h want=%h", bus.result_o, {32'd2, 32'd14});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.ready_o, bus.result_o} !== {1'b1, 32'd2, 32'd14}) begin
      bad++;
      $display("FAIL end_hold got ready=%b result=%h want ready=1 result=%h", bus.ready_o, bus.result_o, {32'd2, 32'd14});
    end
    release_start();
    total++;
    if ({bus.ready_o, bus.result_o} !== 65'h0) begin
      bad++;
      $display("FAIL end_release got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
    end
  endtask

  // Each vector: {signed, dividend, divisor, remainder, quotient}
  task automatic test_divides;
    logic [128:0] vec [9] = '{
      {1'b0, 32'd100,        32'd7,        32'd2,        32'd14},
      {1'b0, 32'hFFFFFFFF,   32'd1,        32'h0,        32'hFFFFFFFF},
      {1'b0, 32'd5,          32'd9,        32'd5,        32'd0},
      {1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0,        32'd1},
      {1'b0, 32'hFFFFFFF9,   32'd2,        32'd1,        32'h7FFFFFFC},
      {1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
      {1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD},
      {1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3},
      {1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000}
    };
    logic [128:0] v;
    int n;
    for (int i = 0; i < 9; i++) begin
      v = vec[i];
      issue(v[128], v[127:96], v[95:64]);
      wait_ready(40, n);
      total++;
      if (n !== 33) begin
        bad++;
        $display("FAIL div%0d_latency got=%0d want=33", i, n);
      end
      total++;
      if (bus.result_o !== v[63:0]) begin
        bad++;
        $display("FAIL div%0d_result got=%h want=%h", i, bus.result_o, v[63:0]);
      end
      release_start();
    end
  endtask

  task automatic test_div_zero;
    int n;
    issue(1'b0, 32'd123, 32'd0);
    wait_ready(5, n);
    total++;
    if (n !== 1 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL divzero got lat=%0d result=%h want lat=1 result=0", n, bus.result_o);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({bus.ready_o, bus.result_o} !== {1'b1, 64'h0}) begin
      bad++;
      $display("FAIL divzero_hold got ready=%b result=%h want ready=1 result=0", bus.ready_o, bus.result_o);
    end
    release_start();
    total++;
    if (bus.ready_o !== 1'b0) begin
      bad++;
      $display("FAIL divzero_release got ready=%b want 0", bus.ready_o);
    end
    issue(1'b1, 32'hFFFFFFF0, 32'd0);
    wait_ready(5, n);
    total++;
    if (n !== 1 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL divzero_signed got lat=%0d result=%h want lat=1 result=0", n, bus.result_o);
    end
    release_start();
  endtask

  task automatic test_annul;
    int n;
    bit seen;
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL annul_no_ready got ready seen=%b want 0", seen);
    end
    issue(1'b0, 32'd20, 32'd3);
    wait_ready(40, n);
    total++;
    if (n !== 33 || bus.result_o !== {32'd2, 32'd6}) begin
      bad++;
      $display("FAIL annul_restart got lat=%0d result=%h want lat=33 result=%h", n, bus.result_o, {32'd2, 32'd6});
    end
    release_start();
    // annul and start together: nothing may start until annul drops.
    @(negedge clk);
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    @(posedge clk);
    wait_ready(40, n);
    total++;
    if (n !== 33 || bus.result_o !== {32'd2, 32'd6}) begin
      bad++;
      $display("FAIL annul_wins got lat=%0d result=%h want lat=33 result=%h", n, bus.result_o, {32'd2, 32'd6});
    end
    // annul is ignored once the result is being held.
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.ready_o, bus.result_o} !== {1'b1, 32'd2, 32'd6}) begin
      bad++;
      $display("FAIL annul_in_end got ready=%b result=%h want ready=1 result=%h", bus.ready_o, bus.result_o, {32'd2, 32'd6});
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    release_start();
  endtask

  task automatic test_operand_hold;
    int n;
    issue(1'b0, 32'd100, 32'd7);
    #2;
    bus.opdata1_i = 32'd999;
    bus.opdata2_i = 32'd0;
    bus.signed_div_i = 1'b1;
    wait_ready(40, n);
    total++;
    if (n !== 33 || bus.result_o !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL operand_hold got lat=%0d result=%h want lat=33 result=%h", n, bus.result_o, {32'd2, 32'd14});
    end
    release_start();
  endtask

  task automatic test_async_reset;
    int n;
    issue(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.ready_o, bus.result_o} !== 65'h0) begin
      bad++;
      $display("FAIL rst_mid_div got ready=%b result=%h want 0", bus.ready_o, bus.result_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd3;
    @(posedge clk);
    wait_ready(40, n);
    total++;
    if (n !== 33 || bus.result_o !== {32'd2, 32'd6}) begin
      bad++;
      $display("FAIL rst_then_start got lat=%0d result=%h want lat=33 result=%h", n, bus.result_o, {32'd2, 32'd6});
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.ready_o, bus.result_o} !== 65'h0) begin
      bad++;
      $display("FAIL rst_in_end got ready=%b result=%h want 0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divides();
    test_div_zero();
    test_annul();
    test_operand_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
